vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 150 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: registered sync, blank, position and frame-start outputs.
// Define VGA_TIMING_GEN_PATTERN_EN for an 8-bar colour test pattern instead of a flat fill.
module vga_timing_gen #(
  parameter int c_h_visible = 640,
  parameter int c_h_front   = 16,
  parameter int c_h_sync    = 96,
  parameter int c_h_back    = 48,
  parameter int c_v_visible = 480,
  parameter int c_v_front   = 10,
  parameter int c_v_sync    = 2,
  parameter int c_v_back    = 33,
  parameter int c_sync_pol  = 0
) (
  input  logic        clk_pixel,
  input  logic        resetn,
  input  logic        clk_pixel_ena,
  output logic [7:0]  o_r,
  output logic [7:0]  o_g,
  output logic [7:0]  o_b,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_blank,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic        o_frame
);

  localparam logic [11:0] H_VIS  = 12'(c_h_visible);
  localparam logic [11:0] HS_BEG = 12'(c_h_visible + c_h_front);
  localparam logic [11:0] HS_END = 12'(c_h_visible + c_h_front + c_h_sync);
  localparam logic [11:0] H_LAST = 12'(c_h_visible + c_h_front + c_h_sync + c_h_back - 1);
  localparam logic [11:0] V_VIS  = 12'(c_v_visible);
  localparam logic [11:0] VS_BEG = 12'(c_v_visible + c_v_front);
  localparam logic [11:0] VS_END = 12'(c_v_visible + c_v_front + c_v_sync);
  localparam logic [11:0] V_LAST = 12'(c_v_visible + c_v_front + c_v_sync + c_v_back - 1);
  localparam logic        SYNC_ON = (c_sync_pol != 0);

  logic [11:0] hc_q, hc_d, vc_q, vc_d;
  logic [11:0] x_q, y_q;
  logic        hs_q, vs_q, blank_q, frame_q;
  logic [7:0]  r_q, g_q, b_q;
  logic [7:0]  r_d, g_d, b_d;
  logic        h_wrap, active, hs_on, vs_on;

  always_comb begin
    h_wrap = (hc_q == H_LAST);
    hc_d   = hc_q;
    vc_d   = vc_q;
    if (clk_pixel_ena) begin
      if (h_wrap) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + 12'd1;
      end else begin
        hc_d = hc_q + 12'd1;
      end
    end
  end

  assign active = (hc_q < H_VIS) && (vc_q < V_VIS);
  assign hs_on  = (hc_q >= HS_BEG) && (hc_q < HS_END);
  assign vs_on  = (vc_q >= VS_BEG) && (vc_q < VS_END);

`ifdef VGA_TIMING_GEN_PATTERN_EN
  localparam int unsigned BAR_W    = (c_h_visible >= 8) ? c_h_visible / 8 : 1;
  localparam logic [11:0] BAR_LAST = 12'(BAR_W - 1);

  logic [11:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]  bar_idx_q, bar_idx_d;

  // Bar index tracks hc in lock-step; bar 7 never advances so it absorbs the remainder.
  always_comb begin
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    if (clk_pixel_ena) begin
      if (h_wrap) begin
        bar_cnt_d = '0;
        bar_idx_d = '0;
      end else if ((bar_cnt_q == BAR_LAST) && (bar_idx_q != 3'd7)) begin
        bar_cnt_d = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + 12'd1;
      end
    end
  end

  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
    end else begin
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
    end
  end

  always_comb begin
    r_d = {8{bar_idx_q[2]}};
    g_d = {8{bar_idx_q[1]}};
    b_d = {8{bar_idx_q[0]}};
  end
`else
  always_comb begin
    r_d = 8'h50;
    g_d = 8'h30;
    b_d = 8'h20;
  end
`endif

  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      hc_q    <= '0;
      vc_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      blank_q <= 1'b1;
      hs_q    <= ~SYNC_ON;
      vs_q    <= ~SYNC_ON;
      frame_q <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
      if (clk_pixel_ena) begin
        x_q     <= hc_q;
        y_q     <= vc_q;
        blank_q <= ~active;
        hs_q    <= hs_on ? SYNC_ON : ~SYNC_ON;
        vs_q    <= vs_on ? SYNC_ON : ~SYNC_ON;
        frame_q <= (hc_q == '0) && (vc_q == '0);
        r_q     <= active ? r_d : '0;
        g_q     <= active ? g_d : '0;
        b_q     <= active ? b_d : '0;
      end
    end
  end

  assign o_x     = x_q;
  assign o_y     = y_q;
  assign o_blank = blank_q;
  assign o_hsync = hs_q;
  assign o_vsync = vs_q;
  assign o_frame = frame_q;
  assign o_r     = r_q;
  assign o_g     = g_q;
  assign o_b     = b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: two reduced-geometry instances (both polarities)
// and one default-geometry instance, all checked against an arithmetic raster model.
module tb_vga_timing_gen;

  localparam int SHV = 42, SHF = 4, SHS = 6, SHB = 5;
  localparam int SVV = 6,  SVF = 2, SVS = 2, SVB = 3;

  typedef struct {
    int x; int y; bit blank; bit hs; bit vs; bit frame; int r; int g; int b;
  } exp_t;
  typedef struct { exp_t s; exp_t d; } rec_t;

  logic clk_pixel, resetn, clk_pixel_ena;
  logic [7:0]  s_r, s_g, s_b, p_r, p_g, p_b, d_r, d_g, d_b;
  logic        s_hs, s_vs, s_bl, s_fr, p_hs, p_vs, p_bl, p_fr, d_hs, d_vs, d_bl, d_fr;
  logic [11:0] s_x, s_y, p_x, p_y, d_x, d_y;

  int   n_cmp = 0, n_bad = 0;
  rec_t sb[$];
  int   fper[$], hper[$];
  rec_t cur;
  int   p;

  vga_timing_gen #(
    .c_h_visible(SHV), .c_h_front(SHF), .c_h_sync(SHS), .c_h_back(SHB),
    .c_v_visible(SVV), .c_v_front(SVF), .c_v_sync(SVS), .c_v_back(SVB), .c_sync_pol(0)
  ) u_sml (
    .clk_pixel(clk_pixel), .resetn(resetn), .clk_pixel_ena(clk_pixel_ena),
    .o_r(s_r), .o_g(s_g), .o_b(s_b), .o_hsync(s_hs), .o_vsync(s_vs), .o_blank(s_bl),
    .o_x(s_x), .o_y(s_y), .o_frame(s_fr)
  );

  vga_timing_gen #(
    .c_h_visible(SHV), .c_h_front(SHF), .c_h_sync(SHS), .c_h_back(SHB),
    .c_v_visible(SVV), .c_v_front(SVF), .c_v_sync(SVS), .c_v_back(SVB), .c_sync_pol(1)
  ) u_pol (
    .clk_pixel(clk_pixel), .resetn(resetn), .clk_pixel_ena(clk_pixel_ena),
    .o_r(p_r), .o_g(p_g), .o_b(p_b), .o_hsync(p_hs), .o_vsync(p_vs), .o_blank(p_bl),
    .o_x(p_x), .o_y(p_y), .o_frame(p_fr)
  );

  vga_timing_gen u_def (
    .clk_pixel(clk_pixel), .resetn(resetn), .clk_pixel_ena(clk_pixel_ena),
    .o_r(d_r), .o_g(d_g), .o_b(d_b), .o_hsync(d_hs), .o_vsync(d_vs), .o_blank(d_bl),
    .o_x(d_x), .o_y(d_y), .o_frame(d_fr)
  );

  initial begin
    clk_pixel = 1'b0;
    forever #5 clk_pixel = ~clk_pixel;
  end

  // Pixel p (count of enabled cycles since reset) sits at hc = p mod H_TOTAL on line (p div H_TOTAL) mod V_TOTAL.
  function automatic exp_t model(int pix, int hv, int hf, int hsw, int hb,
                                 int vv, int vf, int vsw, int vb);
    exp_t e;
    int ht, vt, hc, vc, bar;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    hc = pix % ht;
    vc = (pix / ht) % vt;
    e.x = hc;
    e.y = vc;
    e.blank = !(hc < hv && vc < vv);
    e.hs = (hc >= hv + hf) && (hc < hv + hf + hsw);
    e.vs = (vc >= vv + vf) && (vc < vv + vf + vsw);
    e.frame = (hc == 0) && (vc == 0);
    e.r = 0; e.g = 0; e.b = 0;
    if (!e.blank) begin
`ifdef VGA_TIMING_GEN_PATTERN_EN
      bar = hc / (hv / 8);
      if (bar > 7) bar = 7;
      e.r = ((bar >> 2) & 1) ? 255 : 0;
      e.g = ((bar >> 1) & 1) ? 255 : 0;
      e.b = (bar & 1) ? 255 : 0;
`else
      bar = 0;
      e.r = 'h50; e.g = 'h30; e.b = 'h20;
`endif
    end
    return e;
  endfunction

  function automatic exp_t rst_exp();
    exp_t e;
    e.x = 0; e.y = 0; e.blank = 1'b1; e.hs = 1'b0; e.vs = 1'b0; e.frame = 1'b0;
    e.r = 0; e.g = 0; e.b = 0;
    return e;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_set(string tag, exp_t e, bit pol, logic [11:0] x, logic [11:0] y,
                         logic bl, logic hs, logic vs, logic fr,
                         logic [7:0] r, logic [7:0] g, logic [7:0] b);
    chk({tag, ".x"}, int'(x), e.x);
    chk({tag, ".y"}, int'(y), e.y);
    chk({tag, ".blank"}, int'(bl), int'(e.blank));
    chk({tag, ".hsync"}, int'(hs), int'(e.hs ? pol : !pol));
    chk({tag, ".vsync"}, int'(vs), int'(e.vs ? pol : !pol));
    chk({tag, ".frame"}, int'(fr), int'(e.frame));
    chk({tag, ".r"}, int'(r), e.r);
    chk({tag, ".g"}, int'(g), e.g);
    chk({tag, ".b"}, int'(b), e.b);
  endtask

  task automatic cycle(bit en);
    @(negedge clk_pixel);
    clk_pixel_ena = en;
    if (en) begin
      cur.s = model(p, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB);
      cur.d = model(p, 640, 16, 96, 48, 480, 10, 2, 33);
      p++;
    end
    sb.push_back(cur);
  endtask

  // Reset is asserted between edges and checked before the next edge, so clearing must be asynchronous.
  task automatic do_reset();
    @(posedge clk_pixel);
    #2;
    resetn = 1'b0;
    clk_pixel_ena = 1'b0;
    #1;
    cmp_set("rst_s", rst_exp(), 1'b0, s_x, s_y, s_bl, s_hs, s_vs, s_fr, s_r, s_g, s_b);
    cmp_set("rst_p", rst_exp(), 1'b1, p_x, p_y, p_bl, p_hs, p_vs, p_fr, p_r, p_g, p_b);
    cmp_set("rst_d", rst_exp(), 1'b0, d_x, d_y, d_bl, d_hs, d_vs, d_fr, d_r, d_g, d_b);
    p = 0;
    cur.s = rst_exp();
    cur.d = rst_exp();
    repeat (2) @(posedge clk_pixel);
    #2;
    fper.delete();
    hper.delete();
    resetn = 1'b1;
  endtask

  task automatic chk_periods(string name, int pq[$], int exp);
    chk({name, ".count"}, int'(pq.size() > 0), 1);
    foreach (pq[i]) chk(name, pq[i], exp);
  endtask

  initial begin : monitor
    rec_t r;
    int   clkcnt, f_last, h_last;
    bit   f_valid, h_valid, f_prev, h_prev;
    clkcnt = 0; f_last = 0; h_last = 0;
    f_valid = 0; h_valid = 0; f_prev = 0; h_prev = 1;
    forever begin
      @(posedge clk_pixel);
      #1;
      if (!resetn) begin
        f_valid = 0; h_valid = 0; f_prev = 0; h_prev = 1;
      end else begin
        clkcnt++;
        if (s_fr && !f_prev) begin
          if (f_valid) fper.push_back(clkcnt - f_last);
          f_last = clkcnt;
          f_valid = 1;
        end
        f_prev = s_fr;
        if (!d_hs && h_prev) begin
          if (h_valid) hper.push_back(clkcnt - h_last);
          h_last = clkcnt;
          h_valid = 1;
        end
        h_prev = d_hs;
      end
      if (sb.size() > 0) begin
        r = sb.pop_front();
        cmp_set("sml", r.s, 1'b0, s_x, s_y, s_bl, s_hs, s_vs, s_fr, s_r, s_g, s_b);
        cmp_set("pol", r.s, 1'b1, p_x, p_y, p_bl, p_hs, p_vs, p_fr, p_r, p_g, p_b);
        cmp_set("def", r.d, 1'b0, d_x, d_y, d_bl, d_hs, d_vs, d_fr, d_r, d_g, d_b);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    resetn = 1'b1;
    clk_pixel_ena = 1'b0;
    p = 0;
    cur.s = rst_exp();
    cur.d = rst_exp();

    // Continuous enable: frame and line periods, first-line colours of the default geometry.
    do_reset();
    repeat (1600) cycle(1'b1);
    chk_periods("frame_period_ena1", fper, 741);
    chk_periods("hsync_period_def", hper, 800);

    // Mid-frame reset then restart from 0,0.
    do_reset();
    repeat ($urandom_range(300, 500)) cycle(1'b1);
    do_reset();
    repeat (200) cycle(1'b1);

    // Alternating enable doubles every period in clocks.
    do_reset();
    for (int i = 0; i < 3100; i++) cycle((i % 2) == 0);
    chk_periods("frame_period_alt", fper, 1482);

    // Random enable with one random-point reset.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      cycle(1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk_pixel);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
